md_hilo_unit: RTL
=================

// Module: md_hilo_unit
// PURPOSE
//   Multiply/divide back end and HI/LO register pair for the EX stage, directly downstream of the ALU.
//   Latches the ALU's 64-bit product {Result2,Result} and handles MTHI/MTLO in one cycle.
//   Replaces the ALU's combinational X/Y and X%Y with an iterative restoring divider (33 cycles).
//   Drives busy to stall the pipeline until HI/LO are valid.
// PARAMETERS
//   WIDTH   32   operand and HI/LO width; fixed at 32 in this revision
// PORTS
//   clk       in   1      single clock, rising edge
//   rst_n     in   1      asynchronous, active-low reset
//   op_valid  in   1      op_code/x/y/prod_* valid this cycle
//   op_code   in   3      0 NOP, 1 MTHI, 2 MTLO, 3 MULWR, 4 DIVU, 5 DIV, 6-7 reserved (NOP)
//   x         in   WIDTH  dividend, or MTHI/MTLO source
//   y         in   WIDTH  divisor
//   prod_lo   in   WIDTH  ALU Result (product low)
//   prod_hi   in   WIDTH  ALU Result2 (product high)
//   busy      out  1      divider running; upstream holds the op and stalls
//   done      out  1      one-cycle pulse after HI/LO update
//   hi        out  WIDTH  HI register (remainder / product high)
//   lo        out  WIDTH  LO register (quotient / product low)
//   div0      out  1      only with MD_DIV0_FLAG_EN: last divide had y==0
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0, div0=0; any running divide is aborted.
//   An op is accepted on a rising edge when op_valid=1 and busy=0.
//   op_valid while busy=1 is ignored; upstream must hold it.
//   MTHI/MTLO/MULWR: hi and/or lo are written at the accepting edge.
//     done=1 the following cycle; busy stays 0.
//   MULWR writes hi=prod_hi, lo=prod_lo. MTHI and MTLO leave the other register unchanged.
//   NOP and reserved codes: no state change, no done.
//   FSM states: IDLE -> DIV_RUN (on accepted DIVU/DIV) -> DIV_FIX -> IDLE.
//   Accept edge: latch |x| and |y| (magnitudes for DIV, raw for DIVU), sign_q=x[31]^y[31], sign_r=x[31].
//     Clear the 33-bit partial remainder and set cnt=0.
//   DIV_RUN: one restoring step per edge, MSB first.
//     Step: rem={rem,q_msb}; on rem>=d, subtract and shift in 1, else shift in 0.
//     After 32 steps (cnt==31), go to DIV_FIX.
//   DIV_FIX edge: for DIV, lo = sign_q ? -q : q and hi = sign_r ? -r : r; DIVU writes q and r unchanged.
//     Then state=IDLE, done=1 in the next cycle.
//   busy is registered, (state!=IDLE): high for exactly 33 cycles after the accepting edge.
//   Results follow truncate-toward-zero; the remainder takes the dividend's sign.
//   DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000 (wraps), hi=0.
//   hi/lo hold old values for the whole divide; they change only at the DIV_FIX edge.
//   Reset asserted mid-divide: HI/LO go to 0, no done pulse.
// CONFIGURATION
//   MD_DIV0_FLAG_EN defined: y==0 on an accepted DIV/DIVU skips DIV_RUN.
//     Next edge is DIV_FIX-equivalent: lo=0xFFFFFFFF, hi=x, div0=1, busy high for 1 cycle.
//     div0 is cleared by the next accepted divide with y!=0.
//   Not defined: y==0 runs the full 33 cycles; natural restoring result is lo=0xFFFFFFFF, hi=|x|.
//     For DIV, signs are then applied as usual. The div0 port is absent.
// STRUCTURE
//   md_pkg: WIDTH constant, op_code localparams (MD_NOP..MD_DIV), FSM state encoding, CNT_W=5.
//   Sub-module md_div_core: iterative restoring divider (start, magnitudes in; q, r, last out).
//     md_hilo_unit owns op decode, sign handling, the FSM, HI/LO and handshake.
// TESTING
//   1 Reset then MULWR prod_hi=0x1, prod_lo=0x2 -> next cycle hi=0x1, lo=0x2, done=1, busy=0.
//   2 DIVU x=100, y=7 -> busy 33 cycles; then lo=14, hi=2, done pulse; hi/lo unchanged while busy.
//   3 DIV x=-7 (0xFFFFFFF9), y=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//   4 DIV x=0x80000000, y=0xFFFFFFFF -> lo=0x80000000, hi=0.
//     MTLO 0x55 issued during busy is ignored until it is re-presented after busy drops.
//   5 Start DIVU, assert rst_n=0 at cycle 10 -> busy=0, hi=lo=0 immediately, no done.
//     After release, MTHI 0xAB -> hi=0xAB.
//   6 DIVU x=9, y=0: with MD_DIV0_FLAG_EN, busy 1 cycle, lo=0xFFFFFFFF, hi=9, div0=1.
//     Without the macro, busy 33 cycles with the same hi/lo.

Source files
------------

// File: rtl/md_pkg.sv
// Shared constants for the EX-stage multiply/divide back end.
// Op codes, FSM encoding and counter width.
package md_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MTHI  = 3'd1;
  localparam logic [2:0] MD_MTLO  = 3'd2;
  localparam logic [2:0] MD_MULWR = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_DIV   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIV_RUN = 2'd1,
    S_DIV_FIX = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
// Ports: clk, rst_n, start/a/b (load), step (advance), last, q, r.
module md_div_core
  import md_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   trial;
  logic             ge;

  // Remainder stays below the divisor, so 32 bits hold it;
  // the shifted-in trial needs the 33rd bit only for the compare.
  assign trial = {r_q, q_q[WIDTH-1]};
  assign ge    = trial >= {1'b0, d_q};

  always_comb begin
    q_d   = q_q;
    r_d   = r_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    if (start) begin
      q_d   = a;
      d_d   = b;
      r_d   = '0;
      cnt_d = '0;
    end else if (step) begin
      r_d   = ge ? (trial[WIDTH-1:0] - d_q)
                 : trial[WIDTH-1:0];
      q_d   = {q_q[WIDTH-2:0], ge};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      r_q   <= r_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == {CNT_W{1'b1}});
  assign q    = q_q;
  assign r    = r_q;

endmodule

// File: rtl/md_hilo_unit.sv
// HI/LO pair with MTHI/MTLO/MULWR writes and a 33-cycle iterative divider.
// Ports: op_valid/op_code/x/y/prod_*, busy, done, hi, lo; div0 with MD_DIV0_FLAG_EN.
module md_hilo_unit
  import md_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] prod_lo,
  input  logic [WIDTH-1:0] prod_hi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
`ifdef MD_DIV0_FLAG_EN
  output logic [WIDTH-1:0] lo,
  output logic             div0
`else
  output logic [WIDTH-1:0] lo
`endif
);

  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;

  logic             accept;
  logic             is_mthi, is_mtlo, is_mul;
  logic             is_divu, is_sdiv, is_div;
  logic [WIDTH-1:0] ax, ay;
  logic             core_start, core_step;
  logic             core_last;
  logic [WIDTH-1:0] core_q, core_r;

`ifdef MD_DIV0_FLAG_EN
  logic             z_q, z_d;
  logic             div0_q, div0_d;
  logic             y_zero;
  assign y_zero = (y == '0);
`endif

  assign accept  = op_valid && (state_q == S_IDLE);
  assign is_mthi = accept && (op_code == MD_MTHI);
  assign is_mtlo = accept && (op_code == MD_MTLO);
  assign is_mul  = accept && (op_code == MD_MULWR);
  assign is_divu = accept && (op_code == MD_DIVU);
  assign is_sdiv = accept && (op_code == MD_DIV);
  assign is_div  = is_divu || is_sdiv;

  assign ax = (is_sdiv && x[WIDTH-1]) ? -x : x;
  assign ay = (is_sdiv && y[WIDTH-1]) ? -y : y;

  assign core_start = is_div;
  assign core_step  = (state_q == S_DIV_RUN);

  md_div_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (core_start),
    .step  (core_step),
    .a     (ax),
    .b     (ay),
    .last  (core_last),
    .q     (core_q),
    .r     (core_r)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    sq_d    = sq_q;
    sr_d    = sr_q;
`ifdef MD_DIV0_FLAG_EN
    z_d     = z_q;
    div0_d  = div0_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          is_mthi: begin
            hi_d   = x;
            done_d = 1'b1;
          end
          is_mtlo: begin
            lo_d   = x;
            done_d = 1'b1;
          end
          is_mul: begin
            hi_d   = prod_hi;
            lo_d   = prod_lo;
            done_d = 1'b1;
          end
          is_div: begin
            sq_d    = is_sdiv && (x[WIDTH-1] ^ y[WIDTH-1]);
            sr_d    = is_sdiv && x[WIDTH-1];
            state_d = S_DIV_RUN;
`ifdef MD_DIV0_FLAG_EN
            z_d = y_zero;
            if (y_zero) state_d = S_DIV_FIX;
            else        div0_d  = 1'b0;
`endif
          end
          default: ;
        endcase
      end
      S_DIV_RUN: begin
        if (core_last) state_d = S_DIV_FIX;
      end
      S_DIV_FIX: begin
        lo_d    = sq_q ? -core_q : core_q;
        hi_d    = sr_q ? -core_r : core_r;
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef MD_DIV0_FLAG_EN
        // Core never stepped, so q still holds |x|;
        // re-signing it reproduces the raw dividend.
        if (z_q) begin
          lo_d   = '1;
          hi_d   = sr_q ? -core_q : core_q;
          div0_d = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
`ifdef MD_DIV0_FLAG_EN
      z_q     <= 1'b0;
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
`ifdef MD_DIV0_FLAG_EN
      z_q     <= z_d;
      div0_q  <= div0_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MD_DIV0_FLAG_EN
  assign div0 = div0_q;
`endif

endmodule
